vram_arbiter: RTL

Shares the single 64 KiB video/system RAM port between the CPU and up to NREQ DMA masters: the video line-cache fetcher, a blitter, and the sound fetcher. It requests the bus from the CPU with `hold` and stalls while the CPU is mid-access. It then grants one master at a time in round-robin order and muxes that master's address and read strobe onto the memory port. Read data returns to the owning master with a per-master valid strobe.

---
 rtl/vram_arb_pkg.sv | 21 ++
 rtl/vram_arbiter_rr_picker.sv | 36 +++
 rtl/vram_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and widths for the VRAM bus arbiter.
// Pure declarations: no logic and no latency.
package vram_arb_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int MAX_NREQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETTLE = 2'd1,
    ARB_GRANT  = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the search starts at ptr and wraps at NREQ-1.
// Zero latency and no backpressure; any_req flags that winner is meaningful.
module rr_picker
  import vram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  function automatic logic [IW:0] wrap_add(input logic [IW-1:0] p, input int k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
    return s;
  endfunction

  // Scan offsets from farthest to nearest so the closest requester to ptr is written last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (wrap_add(ptr, k) == (IW+1)'(i))) begin
          winner  = IW'(i);
          any_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the VRAM port between the CPU (stalled via hold) and NREQ DMA masters, round-robin.
// Read data returns MEM_LAT cycles after mem_cs; VRAM_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST reads.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MEM_LAT   = 1,
  parameter int SETTLE    = 1,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          rd,
  input  logic [ADDR_W*NREQ-1:0]   addr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     vrambusy,
  output logic                     hold,
  output logic                     mem_cs,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IW = idx_w(NREQ);
  localparam int SW = idx_w(SETTLE + 1);
  localparam int PW = IW + 1;

  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_SETTLE = ARB_SETTLE;
  localparam logic [1:0] ST_GRANT  = ARB_GRANT;
  localparam logic [1:0] ST_DRAIN  = ARB_DRAIN;

  // Every stage except the output stage must be empty before the bus is handed back.
  localparam logic [MEM_LAT-1:0] EARLY_MASK = MEM_LAT'((1 << (MEM_LAT - 1)) - 1);

  logic [1:0]          state;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       pick;
  logic                pick_any;
  logic [SW-1:0]       settle_cnt;
  logic                slot_wait;
  logic                granted;
  logic                rd_w;
  logic                req_w;
  logic [ADDR_W-1:0]   addr_w;
  logic                accept;
  logic                burst_done;
  logic [PW*MEM_LAT-1:0] vp;
  logic [MEM_LAT-1:0]  stage_vld;
  logic                early_busy;
  logic                last_vld;
  logic [IW-1:0]       last_idx;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .winner  (pick),
    .any_req (pick_any)
  );

  always_comb begin
    rd_w   = 1'b0;
    req_w  = 1'b0;
    addr_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        rd_w   = rd[i];
        req_w  = req[i];
        addr_w = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign granted  = (state == ST_GRANT);
  assign accept   = granted & rd_w;
  assign mem_cs   = accept;
  assign mem_addr = granted ? addr_w : '0;

`ifdef VRAM_ARB_BURST_LIMIT_EN
  logic [6:0] burst_cnt;

  assign burst_done = accept && (burst_cnt == 7'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst || !granted) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + 7'd1;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  // Each stage holds {valid, master index}; the stage shifted out is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      vp <= '0;
    end else begin
      vp <= (PW*MEM_LAT)'({vp, accept, winner});
    end
  end

  for (genvar g = 0; g < MEM_LAT; g++) begin : g_stage
    assign stage_vld[g] = vp[g*PW + IW];
  end

  assign early_busy = |(stage_vld & EARLY_MASK);
  assign last_vld   = stage_vld[MEM_LAT-1];
  assign last_idx   = vp[PW*(MEM_LAT-1) +: IW];
  assign rvalid     = last_vld ? (NREQ'(1) << last_idx) : '0;
  assign rdata      = last_vld ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      winner     <= '0;
      ptr        <= '0;
      settle_cnt <= '0;
      gnt        <= '0;
      hold       <= 1'b0;
      slot_wait  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // slot_wait keeps hold low one extra cycle so the CPU always gets a turn.
          slot_wait <= 1'b0;
          if (pick_any && !vrambusy && !slot_wait) begin
            winner     <= pick;
            hold       <= 1'b1;
            settle_cnt <= SW'(SETTLE);
            if (SETTLE == 0) begin
              gnt   <= NREQ'(1) << pick;
              state <= ST_GRANT;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt <= SW'(1)) begin
            gnt   <= NREQ'(1) << winner;
            state <= ST_GRANT;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        ST_GRANT: begin
          if (!req_w || burst_done) begin
            gnt   <= '0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!early_busy) begin
            hold      <= 1'b0;
            ptr       <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
            slot_wait <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
